// File: rtl/ram_dma_engine.sv
`default_nettype none
// ============================================================================
//  Module      : ram_dma_engine
//  Description : Block-copy initiator for a dual-port scratch RAM (sync write
//                on port X, async read on ports X/Y). When idle, the CPU port
//                passes straight through to the RAM. A START request takes
//                over the RAM and copies Leff = min(LEN, 2**ADDR_SIZE) words
//                from SRC to DST at one word per clock: read on Y, write on X.
//                The copy direction is chosen so that overlapping blocks copy
//                correctly (memmove semantics).
//  Optional    : `define DMA_FILL_EN adds FILL/PAT ports. When FILL is set
//                with START, the latched PAT word is written to
//                DST..DST+Leff-1 (always ascending) instead of copying.
//  Ports       :
//    CLK, RST                 clock, synchronous active-high reset
//    START, SRC, DST, LEN     transfer request and parameters (IDLE only)
//    FILL, PAT                fill request and pattern (DMA_FILL_EN only)
//    BUSY, DONE               registered status: copying / one-cycle finish
//    CPU_ADRX/ADRY/DIN/WE     CPU side of the RAM port
//    RAM_ADRX/ADRY/DIN/WE     RAM side of the RAM port
//    RAM_DY                   RAM async read data from port Y
//  Revision    : 1.0  initial release
// ============================================================================
module ram_dma_engine #(
    parameter int ADDR_SIZE = 5,
    parameter int DATA_SIZE = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [ADDR_SIZE-1:0] SRC,
    input  logic [ADDR_SIZE-1:0] DST,
    input  logic [ADDR_SIZE:0]   LEN,
`ifdef DMA_FILL_EN
    input  logic                 FILL,
    input  logic [DATA_SIZE-1:0] PAT,
`endif
    output logic                 BUSY,
    output logic                 DONE,
    input  logic [ADDR_SIZE-1:0] CPU_ADRX,
    input  logic [ADDR_SIZE-1:0] CPU_ADRY,
    input  logic [DATA_SIZE-1:0] CPU_DIN,
    input  logic                 CPU_WE,
    output logic [ADDR_SIZE-1:0] RAM_ADRX,
    output logic [ADDR_SIZE-1:0] RAM_ADRY,
    output logic [DATA_SIZE-1:0] RAM_DIN,
    output logic                 RAM_WE,
    input  logic [DATA_SIZE-1:0] RAM_DY
);

    // RAM depth as a count value, and unit steps for pointer/count arithmetic
    localparam logic [ADDR_SIZE:0]   c_DEPTH   = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [ADDR_SIZE-1:0] c_ONE     = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
    localparam logic [ADDR_SIZE:0]   c_CNT_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COPY = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_SIZE-1:0]   r_sptr;
    logic [ADDR_SIZE-1:0]   r_dptr;
    logic [ADDR_SIZE:0]     r_cnt;
    logic                   r_desc;
    logic                   r_busy;
    logic                   r_done;

    logic [ADDR_SIZE:0]     w_leff;
    logic [ADDR_SIZE-1:0]   w_diff;
    logic [ADDR_SIZE-1:0]   w_lm1;
    logic                   w_desc;
    logic [ADDR_SIZE-1:0]   w_sptr_init;
    logic [ADDR_SIZE-1:0]   w_dptr_init;
    logic                   w_accept;

    logic                   w_fill_req;
    logic                   w_fill_act;
    logic [DATA_SIZE-1:0]   w_fill_din;

    // ------------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ------------------------------------------------------------------------
    assign w_accept = (r_state == S_IDLE) && START;
    assign w_leff   = (LEN > c_DEPTH) ? c_DEPTH : LEN;
    assign w_diff   = DST - SRC;
    // Leff-1 modulo depth; for Leff == depth the low bits are 0 and this
    // correctly wraps to depth-1.
    assign w_lm1    = w_leff[ADDR_SIZE-1:0] - c_ONE;

    // A destination lying just above the source inside the block would be
    // overwritten before it is read when copying upwards, so copy downwards.
    // Fills have no source and always run ascending.
    assign w_desc = !w_fill_req && (w_diff != '0) && ({1'b0, w_diff} < w_leff);

    assign w_sptr_init = w_desc ? (SRC + w_lm1) : SRC;
    assign w_dptr_init = w_desc ? (DST + w_lm1) : DST;

    // ------------------------------------------------------------------------
    // Optional fill feature
    // ------------------------------------------------------------------------
`ifdef DMA_FILL_EN
    logic                 r_fill;
    logic [DATA_SIZE-1:0] r_pat;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fill <= 1'b0;
            r_pat  <= '0;
        end else if (w_accept) begin
            r_fill <= FILL;
            r_pat  <= PAT;
        end
    end

    assign w_fill_req = FILL;
    assign w_fill_act = r_fill;
    assign w_fill_din = r_pat;
`else
    assign w_fill_req = 1'b0;
    assign w_fill_act = 1'b0;
    assign w_fill_din = '0;
`endif

    // ------------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_sptr  <= '0;
            r_dptr  <= '0;
            r_cnt   <= '0;
            r_desc  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Status flags are registered copies of the upcoming state
            r_busy  <= (w_state_nxt == S_COPY);
            r_done  <= (w_state_nxt == S_FIN);
            if (w_accept) begin
                r_sptr <= w_sptr_init;
                r_dptr <= w_dptr_init;
                r_cnt  <= w_leff;
                r_desc <= w_desc;
            end else if (r_state == S_COPY) begin
                r_sptr <= r_desc ? (r_sptr - c_ONE) : (r_sptr + c_ONE);
                r_dptr <= r_desc ? (r_dptr - c_ONE) : (r_dptr + c_ONE);
                r_cnt  <= r_cnt - c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and RAM port multiplexing
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        RAM_ADRX    = CPU_ADRX;
        RAM_ADRY    = CPU_ADRY;
        RAM_DIN     = CPU_DIN;
        RAM_WE      = CPU_WE;

        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = (w_leff == '0) ? S_FIN : S_COPY;
                end
            end
            S_COPY: begin
                RAM_ADRX = r_dptr;
                RAM_ADRY = w_fill_act ? CPU_ADRY : r_sptr;
                RAM_DIN  = w_fill_act ? w_fill_din : RAM_DY;
                // Suppress the write on the edge where reset lands so an
                // aborted transfer leaves no further DMA write behind.
                RAM_WE   = !RST;
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_dma_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_dma_engine
//  Description : Self-checking bench for ram_dma_engine. Contains a small
//                dual-port RAM model (sync write X, async read Y), a table of
//                directed copy vectors with hand-computed results, and
//                hand-written sequences for reset, abort, CPU-write blocking,
//                START-during-busy and (with DMA_FILL_EN) fill.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_dma_engine;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [4:0] SRC;
    logic [4:0] DST;
    logic [5:0] LEN;
`ifdef DMA_FILL_EN
    logic       FILL;
    logic [7:0] PAT;
`endif
    logic       BUSY;
    logic       DONE;
    logic [4:0] CPU_ADRX;
    logic [4:0] CPU_ADRY;
    logic [7:0] CPU_DIN;
    logic       CPU_WE;
    logic [4:0] RAM_ADRX;
    logic [4:0] RAM_ADRY;
    logic [7:0] RAM_DIN;
    logic       RAM_WE;
    logic [7:0] RAM_DY;

    logic [7:0] mem [32];

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    ram_dma_engine #(.ADDR_SIZE(5), .DATA_SIZE(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .SRC      (SRC),
        .DST      (DST),
        .LEN      (LEN),
`ifdef DMA_FILL_EN
        .FILL     (FILL),
        .PAT      (PAT),
`endif
        .BUSY     (BUSY),
        .DONE     (DONE),
        .CPU_ADRX (CPU_ADRX),
        .CPU_ADRY (CPU_ADRY),
        .CPU_DIN  (CPU_DIN),
        .CPU_WE   (CPU_WE),
        .RAM_ADRX (RAM_ADRX),
        .RAM_ADRY (RAM_ADRY),
        .RAM_DIN  (RAM_DIN),
        .RAM_WE   (RAM_WE),
        .RAM_DY   (RAM_DY)
    );

    // RAM model
    always @(posedge CLK) begin
        if (RAM_WE) mem[RAM_ADRX] <= RAM_DIN;
    end
    assign RAM_DY = mem[RAM_ADRY];

    typedef struct {
        logic [4:0]  src;
        logic [4:0]  dst;
        logic [5:0]  len;
        logic [31:0] w;      // words preloaded at src..src+3, byte 0 first
        int          n;      // number of destination words to check
        logic [31:0] e;      // expected words at dst..dst+n-1
        logic [4:0]  aadr;   // neighbour address to check afterwards
        logic [7:0]  after;  // expected neighbour value
        int          busy;   // expected BUSY cycles (= Leff)
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cpu_wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge CLK);
        CPU_ADRX = a;
        CPU_DIN  = d;
        CPU_WE   = 1'b1;
        @(posedge CLK);
        #1 CPU_WE = 1'b0;
    endtask

    task automatic bg_init();
        for (int i = 0; i < 32; i++) cpu_wr(5'(i), 8'(8'h80 + i));
    endtask

    // Issue START at the next edge k; count BUSY periods and record the
    // period index j (period j follows edge k+j-1) at which DONE shows up.
    task automatic run_xfer(input logic [4:0] s, input logic [4:0] d, input logic [5:0] l,
                            output int busy_n, output int done_at);
        @(negedge CLK);
        SRC = s; DST = d; LEN = l; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        busy_n  = 0;
        done_at = 0;
        for (int j = 1; j <= 100 && done_at == 0; j++) begin
            @(negedge CLK);
            if (BUSY) busy_n++;
            if (DONE) done_at = j;
        end
        @(negedge CLK);
        check("done_pulse_width", {31'd0, DONE}, 32'd0);
    endtask

    initial begin
        int bn, da, seen;
        logic [4:0] a;

        vt[0] = '{src:5'd0,  dst:5'd16, len:6'd4,  w:32'hA4A3A2A1, n:4, e:32'hA4A3A2A1, aadr:5'd20, after:8'h94, busy:4};
        vt[1] = '{src:5'd2,  dst:5'd4,  len:6'd4,  w:32'h04030201, n:4, e:32'h04030201, aadr:5'd8,  after:8'h88, busy:4};
        vt[2] = '{src:5'd30, dst:5'd0,  len:6'd4,  w:32'h06070809, n:4, e:32'h06070809, aadr:5'd4,  after:8'h84, busy:4};
        vt[3] = '{src:5'd4,  dst:5'd2,  len:6'd4,  w:32'h04030201, n:4, e:32'h04030201, aadr:5'd6,  after:8'h03, busy:4};
        vt[4] = '{src:5'd8,  dst:5'd8,  len:6'd2,  w:32'h44332211, n:2, e:32'h00002211, aadr:5'd10, after:8'h33, busy:2};
        vt[5] = '{src:5'd5,  dst:5'd20, len:6'd0,  w:32'h04030201, n:0, e:32'h0,        aadr:5'd20, after:8'h94, busy:0};
        vt[6] = '{src:5'd0,  dst:5'd0,  len:6'd40, w:32'h08070605, n:4, e:32'h08070605, aadr:5'd4,  after:8'h84, busy:32};

        RST = 1'b1; START = 1'b0; SRC = '0; DST = '0; LEN = '0;
`ifdef DMA_FILL_EN
        FILL = 1'b0; PAT = '0;
`endif
        CPU_ADRX = 5'd9; CPU_ADRY = 5'd12; CPU_DIN = 8'h3C; CPU_WE = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        check("reset_done", {31'd0, DONE}, 32'd0);
        check("idle_adrx",  {27'd0, RAM_ADRX}, 32'd9);
        check("idle_adry",  {27'd0, RAM_ADRY}, 32'd12);
        check("idle_din",   {24'd0, RAM_DIN}, 32'h3C);
        check("idle_we",    {31'd0, RAM_WE}, 32'd1);
        CPU_WE = 1'b0;

        // Table of directed copies
        for (int v = 0; v < 7; v++) begin
            bg_init();
            for (int i = 0; i < 4; i++) cpu_wr(5'(vt[v].src + 5'(i)), vt[v].w[8*i +: 8]);
            run_xfer(vt[v].src, vt[v].dst, vt[v].len, bn, da);
            check($sformatf("v%0d_busy_cycles", v), bn, vt[v].busy);
            check($sformatf("v%0d_done_at", v), da, vt[v].busy + 1);
            for (int i = 0; i < vt[v].n; i++) begin
                a = 5'(vt[v].dst + 5'(i));
                check($sformatf("v%0d_mem[%0d]", v, a), {24'd0, mem[a]}, {24'd0, vt[v].e[8*i +: 8]});
            end
            check($sformatf("v%0d_neighbour[%0d]", v, vt[v].aadr), {24'd0, mem[vt[v].aadr]}, {24'd0, vt[v].after});
        end

        // Reset asserted during the second COPY cycle of an 8-word copy
        bg_init();
        for (int i = 0; i < 4; i++) cpu_wr(5'(i), 8'(8'hA1 + i));
        @(negedge CLK);
        SRC = 5'd0; DST = 5'd16; LEN = 6'd8; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        seen = 0;
        bn = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge CLK);
            if (DONE) seen++;
            if (BUSY) bn++;
        end
        check("abort_busy_after", bn, 0);
        check("abort_no_done", seen, 0);
        check("abort_mem16", {24'd0, mem[16]}, 32'hA1);
        check("abort_mem17", {24'd0, mem[17]}, 32'h91);

        // CPU write and a second START while busy are both dropped
        bg_init();
        @(negedge CLK);
        SRC = 5'd0; DST = 5'd16; LEN = 6'd4; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        @(negedge CLK);
        CPU_ADRX = 5'd25; CPU_DIN = 8'hEE; CPU_WE = 1'b1;
        SRC = 5'd1; DST = 5'd2; LEN = 6'd3; START = 1'b1;
        @(negedge CLK);
        CPU_WE = 1'b0; START = 1'b0;
        da = 0;
        for (int j = 0; j < 20 && da == 0; j++) begin
            @(negedge CLK);
            if (DONE) da = 1;
        end
        check("busywr_done_seen", da, 1);
        bn = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge CLK);
            if (BUSY) bn++;
        end
        check("busywr_no_requeue", bn, 0);
        check("busywr_mem25", {24'd0, mem[25]}, 32'h99);
        check("busywr_mem2", {24'd0, mem[2]}, 32'h82);
        check("busywr_mem16", {24'd0, mem[16]}, 32'h80);
        check("busywr_mem19", {24'd0, mem[19]}, 32'h83);

`ifdef DMA_FILL_EN
        bg_init();
        FILL = 1'b1; PAT = 8'h5A;
        run_xfer(5'd0, 5'd10, 6'd3, bn, da);
        FILL = 1'b0;
        check("fill_busy_cycles", bn, 3);
        check("fill_done_at", da, 4);
        check("fill_mem10", {24'd0, mem[10]}, 32'h5A);
        check("fill_mem11", {24'd0, mem[11]}, 32'h5A);
        check("fill_mem12", {24'd0, mem[12]}, 32'h5A);
        check("fill_mem9",  {24'd0, mem[9]},  32'h89);
        check("fill_mem13", {24'd0, mem[13]}, 32'h8D);
        check("fill_mem0",  {24'd0, mem[0]},  32'h80);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
